// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU control, mul/div ops,
// forwarding selects and the mul/div FSM state type.
package mips_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_ME = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/dff.sv
// Generic register cell with async active-low reset, synchronous clear
// (priority) and load enable.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (clr)  q <= '0;
        else if (en)   q <= d;
    end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative multiply/divide unit with HI/LO. Define MD_FAST_MULT_EN to make
// MULT/MULTU finish in one step from a combinational product.
//
// state | meaning
// IDLE  | waiting for a mul/div start; HI/LO stable
// RUN   | one shift-add / restoring-subtract step per cycle on magnitudes
// FIX   | sign correction and HI/LO write-back
module muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MD_CYCLES);

    md_state_t          r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
    logic               r_is_div, r_neg_q, r_neg_r, r_b_zero;

    logic               w_op_md, w_op_div, w_op_signed, w_go, w_fast;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [2*WIDTH-1:0] w_prod, w_mul_nxt, w_div_nxt, w_prod_fix;
    logic [WIDTH:0]     w_mul_sum, w_div_trial;
    logic [WIDTH-1:0]   w_hi_fix, w_lo_fix;

    always_comb begin
        w_op_md     = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
        w_op_div    = (op == MD_DIV) || (op == MD_DIVU);
        w_op_signed = (op == MD_MULT) || (op == MD_DIV);
        w_go        = start && w_op_md;
        w_a_mag     = (w_op_signed && a[WIDTH-1]) ? -a : a;
        w_b_mag     = (w_op_signed && b[WIDTH-1]) ? -b : b;
        w_prod      = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
        w_fast      = 1'b0;
`ifdef MD_FAST_MULT_EN
        w_fast      = !w_op_div;
`endif
    end

    // Multiply: low half holds the shrinking multiplier, high half the partial sum.
    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    always_comb begin
        w_mul_sum   = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_work[0] ? {1'b0, r_b} : '0);
        w_mul_nxt   = {w_mul_sum, r_work[WIDTH-1:1]};
        w_div_trial = r_work[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
        w_div_nxt   = w_div_trial[WIDTH] ? {r_work[2*WIDTH-2:0], 1'b0}
                                         : {w_div_trial[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        w_prod_fix = r_neg_q ? -r_work : r_work;
        w_hi_fix   = w_prod_fix[2*WIDTH-1:WIDTH];
        w_lo_fix   = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            if (r_b_zero) begin
                w_lo_fix = '1;
                w_hi_fix = r_a;
            end else begin
                w_lo_fix = r_neg_q ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
                w_hi_fix = r_neg_r ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= MD_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (w_go) w_state_nxt = w_fast ? MD_FIX : MD_RUN;
            MD_RUN:  if (r_cnt == '0) w_state_nxt = MD_FIX;
            MD_FIX:  w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_work   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: if (w_go) begin
                    r_cnt    <= CW'(MD_CYCLES - 1);
                    r_a      <= a;
                    r_b      <= w_b_mag;
                    r_is_div <= w_op_div;
                    r_neg_q  <= w_op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_neg_r  <= w_op_signed && a[WIDTH-1];
                    r_b_zero <= (b == '0);
                    r_work   <= w_fast ? w_prod : {{WIDTH{1'b0}}, w_a_mag};
                end
                MD_RUN: begin
                    r_cnt  <= r_cnt - CW'(1);
                    r_work <= r_is_div ? w_div_nxt : w_mul_nxt;
                end
                MD_FIX: begin
                    r_hi <= w_hi_fix;
                    r_lo <= w_lo_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != MD_IDLE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: rtl/execute.sv
// MIPS execute stage: forwarding, ALU, HI/LO read mux and EX pipeline register.
// Optional MD_FAST_MULT_EN selects single-step multiplies in the mul/div unit.
module execute
    import mips_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             AnyStall,
    input  logic [WIDTH-1:0] SrcA_ID,
    input  logic [WIDTH-1:0] SrcB_ID,
    input  logic [WIDTH-1:0] Imm_ID,
    input  logic [4:0]       Shamt_ID,
    input  logic [3:0]       AluCtl_ID,
    input  logic             AluSrc_ID,
    input  logic [2:0]       MdOp_ID,
    input  logic             RegWrite_ID,
    input  logic             MemToReg_ID,
    input  logic             MemWrite_ID,
    input  logic [4:0]       WriteReg_ID,
    input  logic [1:0]       ForwardA_ID,
    input  logic [1:0]       ForwardB_ID,
    input  logic [WIDTH-1:0] Result_ME,
    input  logic [WIDTH-1:0] WbData,
    output logic [WIDTH-1:0] Result_EX,
    output logic [WIDTH-1:0] WrDat_EX,
    output logic             RegWrite_EX,
    output logic             MemToReg_EX,
    output logic             MemWrite_EX,
    output logic [4:0]       WriteReg_EX,
    output logic             MdBusy,
    output logic             MdStall
);

    localparam int EXW = 2*WIDTH + 8;

    logic [WIDTH-1:0] w_fwd_a, w_fwd_b, w_opb, w_alu, w_result, w_hi, w_lo;
    logic             w_busy;
    logic [EXW-1:0]   w_ex_d, w_ex_q;

    always_comb begin
        case (ForwardA_ID)
            FWD_RF:  w_fwd_a = SrcA_ID;
            FWD_ME:  w_fwd_a = Result_ME;
            FWD_WB:  w_fwd_a = WbData;
            default: w_fwd_a = SrcA_ID;
        endcase
        case (ForwardB_ID)
            FWD_RF:  w_fwd_b = SrcB_ID;
            FWD_ME:  w_fwd_b = Result_ME;
            FWD_WB:  w_fwd_b = WbData;
            default: w_fwd_b = SrcB_ID;
        endcase
        w_opb = AluSrc_ID ? Imm_ID : w_fwd_b;
    end

    // Shifts always act on the forwarded rt value, never on the immediate.
    always_comb begin
        case (AluCtl_ID)
            ALU_AND:  w_alu = w_fwd_a & w_opb;
            ALU_OR:   w_alu = w_fwd_a | w_opb;
            ALU_ADD:  w_alu = w_fwd_a + w_opb;
            ALU_XOR:  w_alu = w_fwd_a ^ w_opb;
            ALU_NOR:  w_alu = ~(w_fwd_a | w_opb);
            ALU_SUB:  w_alu = w_fwd_a - w_opb;
            ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_opb))};
            ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (w_fwd_a < w_opb)};
            ALU_SLL:  w_alu = w_fwd_b << Shamt_ID;
            ALU_SRL:  w_alu = w_fwd_b >> Shamt_ID;
            ALU_SRA:  w_alu = $signed(w_fwd_b) >>> Shamt_ID;
            ALU_LUI:  w_alu = {Imm_ID[15:0], 16'b0};
            default:  w_alu = '0;
        endcase
        case (MdOp_ID)
            MD_MFHI: w_result = w_hi;
            MD_MFLO: w_result = w_lo;
            default: w_result = w_alu;
        endcase
    end

    muldiv #(
        .WIDTH     (WIDTH),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (!AnyStall && !flush),
        .op      (MdOp_ID),
        .a       (w_fwd_a),
        .b       (w_fwd_b),
        .busy    (w_busy),
        .hi      (w_hi),
        .lo      (w_lo)
    );

    assign w_ex_d = {w_result, w_fwd_b, RegWrite_ID, MemToReg_ID, MemWrite_ID, WriteReg_ID};

    dff #(.W(EXW)) u_ex_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .en      (!AnyStall),
        .d       (w_ex_d),
        .q       (w_ex_q)
    );

    assign {Result_EX, WrDat_EX, RegWrite_EX, MemToReg_EX, MemWrite_EX, WriteReg_EX} = w_ex_q;

    assign MdBusy  = w_busy;
    assign MdStall = w_busy && (MdOp_ID != MD_NONE);

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage; expected EX-register contents are
// queued when an instruction is driven and compared when it reaches EX.
module tb_execute;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, flush, r_stall, AnyStall;
    logic [31:0] SrcA_ID, SrcB_ID, Imm_ID, Result_ME, WbData;
    logic [4:0]  Shamt_ID, WriteReg_ID;
    logic [3:0]  AluCtl_ID;
    logic        AluSrc_ID, RegWrite_ID, MemToReg_ID, MemWrite_ID;
    logic [2:0]  MdOp_ID;
    logic [1:0]  ForwardA_ID, ForwardB_ID;
    logic [31:0] Result_EX, WrDat_EX;
    logic        RegWrite_EX, MemToReg_EX, MemWrite_EX, MdBusy, MdStall;
    logic [4:0]  WriteReg_EX;
    logic [71:0] obs;

    int errors = 0;
    int checks = 0;
    logic [71:0] exp_q[$];

`ifdef MD_FAST_MULT_EN
    localparam int MULT_BUSY = 1;
`else
    localparam int MULT_BUSY = 33;
`endif

    always #5 clk = ~clk;
    assign AnyStall = r_stall | MdStall;
    assign obs = {Result_EX, WrDat_EX, RegWrite_EX, MemToReg_EX, MemWrite_EX, WriteReg_EX};

    execute dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .AnyStall(AnyStall),
        .SrcA_ID(SrcA_ID), .SrcB_ID(SrcB_ID), .Imm_ID(Imm_ID), .Shamt_ID(Shamt_ID),
        .AluCtl_ID(AluCtl_ID), .AluSrc_ID(AluSrc_ID), .MdOp_ID(MdOp_ID),
        .RegWrite_ID(RegWrite_ID), .MemToReg_ID(MemToReg_ID), .MemWrite_ID(MemWrite_ID),
        .WriteReg_ID(WriteReg_ID), .ForwardA_ID(ForwardA_ID), .ForwardB_ID(ForwardB_ID),
        .Result_ME(Result_ME), .WbData(WbData),
        .Result_EX(Result_EX), .WrDat_EX(WrDat_EX), .RegWrite_EX(RegWrite_EX),
        .MemToReg_EX(MemToReg_EX), .MemWrite_EX(MemWrite_EX), .WriteReg_EX(WriteReg_EX),
        .MdBusy(MdBusy), .MdStall(MdStall)
    );

    typedef struct packed {
        logic [3:0]  ctl;
        logic [31:0] a, b, imm;
        logic        alusrc;
        logic [4:0]  sh;
        logic [1:0]  fa, fb;
        logic [31:0] exp_r, exp_wd;
    } alu_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        SrcA_ID = 0; SrcB_ID = 0; Imm_ID = 0; Shamt_ID = 0; AluCtl_ID = ALU_AND;
        AluSrc_ID = 0; MdOp_ID = MD_NONE; RegWrite_ID = 0; MemToReg_ID = 0;
        MemWrite_ID = 0; WriteReg_ID = 0; ForwardA_ID = 0; ForwardB_ID = 0;
    endtask

    task automatic drive_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        drive_nop();
        MdOp_ID = op; SrcA_ID = a; SrcB_ID = b;
        if (op == MD_MFHI || op == MD_MFLO) begin
            RegWrite_ID = 1; WriteReg_ID = 5'd2;
        end
    endtask

    // Launches a mul/div and returns how many sampled cycles MdBusy stayed high.
    task automatic md_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        drive_md(op, a, b);
        tick();
        drive_nop();
        cyc = 0;
        while (MdBusy && cyc < 200) begin
            cyc++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 0; flush = 0; r_stall = 0; Result_ME = 0; WbData = 0;
        drive_nop();
        #12;
        checks++;
        if (obs !== 72'd0) begin errors++; $display("FAIL reset_ex got=%h want=0", obs); end
        checks++;
        if (MdBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", MdBusy); end
        #2 reset_n = 1;
        tick();
    endtask

    task automatic test_alu_fwd();
        alu_vec_t v[15];
        logic [71:0] e;
        v[0]  = '{ALU_SUB,  32'd5, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 2'b01, 32'hFFFFFFFE, 32'd7};
        v[1]  = '{ALU_ADD,  32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 2'b00, 2'b00, 32'd0, 32'd1};
        v[2]  = '{ALU_SLT,  32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 2'b00, 2'b00, 32'd1, 32'd1};
        v[3]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 2'b00, 2'b00, 32'd0, 32'd1};
        v[4]  = '{ALU_SRA,  32'd0, 32'h80000000, 32'd0, 1'b0, 5'd4, 2'b00, 2'b00, 32'hF8000000, 32'h80000000};
        v[5]  = '{ALU_SRL,  32'd0, 32'h80000000, 32'd0, 1'b0, 5'd4, 2'b00, 2'b00, 32'h08000000, 32'h80000000};
        v[6]  = '{ALU_SLL,  32'd0, 32'd1, 32'd0, 1'b0, 5'd31, 2'b00, 2'b00, 32'h80000000, 32'd1};
        v[7]  = '{ALU_LUI,  32'd0, 32'h55, 32'h0000ABCD, 1'b1, 5'd0, 2'b00, 2'b00, 32'hABCD0000, 32'h55};
        v[8]  = '{ALU_NOR,  32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd0};
        v[9]  = '{ALU_XOR,  32'd0, 32'h0FF00FF0, 32'd0, 1'b0, 5'd0, 2'b10, 2'b00, 32'hFF00FF00, 32'h0FF00FF0};
        v[10] = '{ALU_OR,   32'h10, 32'd1, 32'd0, 1'b0, 5'd0, 2'b11, 2'b00, 32'h11, 32'd1};
        v[11] = '{4'd5,     32'd3, 32'd4, 32'd0, 1'b0, 5'd0, 2'b00, 2'b00, 32'd0, 32'd4};
        v[12] = '{ALU_AND,  32'h1234, 32'h9999, 32'hFF, 1'b1, 5'd0, 2'b00, 2'b00, 32'h34, 32'h9999};
        v[13] = '{ALU_ADD,  32'd1, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 2'b10, 32'hF0F0F0F1, 32'hF0F0F0F0};
        v[14] = '{ALU_SUB,  32'd5, 32'd3, 32'd0, 1'b0, 5'd0, 2'b00, 2'b11, 32'd2, 32'd3};
        Result_ME = 32'd7; WbData = 32'hF0F0F0F0;
        for (int i = 0; i < 15; i++) begin
            drive_nop();
            AluCtl_ID = v[i].ctl; SrcA_ID = v[i].a; SrcB_ID = v[i].b; Imm_ID = v[i].imm;
            AluSrc_ID = v[i].alusrc; Shamt_ID = v[i].sh;
            ForwardA_ID = v[i].fa; ForwardB_ID = v[i].fb;
            RegWrite_ID = 1; MemToReg_ID = i[1]; MemWrite_ID = i[0]; WriteReg_ID = 5'(i);
            exp_q.push_back({v[i].exp_r, v[i].exp_wd, 1'b1, i[1], i[0], 5'(i)});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL alu_vec%0d got=%h want=%h", i, obs, e);
            end
        end
        drive_nop();
    endtask

    task automatic test_stall_flush();
        logic [71:0] e;
        drive_nop();
        AluCtl_ID = ALU_ADD; SrcA_ID = 10; SrcB_ID = 20; RegWrite_ID = 1;
        MemWrite_ID = 1; WriteReg_ID = 9;
        exp_q.push_back({32'd30, 32'd20, 1'b1, 1'b0, 1'b1, 5'd9});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_load got=%h want=%h", obs, e); end
        r_stall = 1;
        SrcA_ID = 1; SrcB_ID = 1; WriteReg_ID = 3; MemWrite_ID = 0;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back({32'd30, 32'd20, 1'b1, 1'b0, 1'b1, 5'd9});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL stall_hold%0d got=%h want=%h", c, obs, e); end
        end
        flush = 1;
        exp_q.push_back(72'd0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL flush_over_stall got=%h want=0", obs); end
        flush = 0; r_stall = 0;
        drive_nop();
    endtask

    task automatic test_div_signed();
        int cyc, stall_bad;
        logic [71:0] e;
        drive_md(MD_DIV, 32'hFFFFFFF9, 32'd2);
        tick();
        drive_nop();
        cyc = 0; stall_bad = 0;
        while (MdBusy && cyc < 200) begin
            cyc++;
            if (cyc == 5) begin
                drive_md(MD_MFLO, 0, 0);
                #1;
            end
            if (cyc >= 5 && MdStall !== 1'b1) stall_bad++;
            tick();
        end
        checks++;
        if (cyc != 33) begin errors++; $display("FAIL div_busy_cycles got=%0d want=33", cyc); end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL mflo_stall missed=%0d want=0", stall_bad); end
        checks++;
        if (MdStall !== 1'b0) begin errors++; $display("FAIL stall_release got=%b want=0", MdStall); end
        exp_q.push_back({32'hFFFFFFFD, 32'd0, 1'b1, 1'b0, 1'b0, 5'd2});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL div_lo got=%h want=%h", obs, e); end
        drive_md(MD_MFHI, 0, 0);
        exp_q.push_back({32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1'b0, 5'd2});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL div_hi got=%h want=%h", obs, e); end
        drive_nop();
    endtask

    // Runs op, then reads LO and HI through the pipeline and checks both.
    task automatic test_md_case(input string nm, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int busy_exp,
                                input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        int cyc;
        logic [71:0] e;
        md_run(op, a, b, cyc);
        checks++;
        if (cyc != busy_exp) begin errors++; $display("FAIL %s_busy got=%0d want=%0d", nm, cyc, busy_exp); end
        drive_md(MD_MFLO, 0, 0);
        exp_q.push_back({lo_exp, 32'd0, 1'b1, 1'b0, 1'b0, 5'd2});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL %s_lo got=%h want=%h", nm, obs, e); end
        drive_md(MD_MFHI, 0, 0);
        exp_q.push_back({hi_exp, 32'd0, 1'b1, 1'b0, 1'b0, 5'd2});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL %s_hi got=%h want=%h", nm, obs, e); end
        drive_nop();
    endtask

    task automatic test_flush_no_start();
        drive_md(MD_DIV, 32'd5, 32'd1);
        flush = 1;
        tick();
        flush = 0;
        drive_nop();
        checks++;
        if (MdBusy !== 1'b0 || obs !== 72'd0) begin
            errors++; $display("FAIL flush_no_start busy=%b ex=%h want busy=0 ex=0", MdBusy, obs);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [71:0] e;
        drive_md(MD_DIVU, 32'd100, 32'd7);
        tick();
        drive_nop();
        AluCtl_ID = ALU_ADD; SrcA_ID = 1; SrcB_ID = 2; RegWrite_ID = 1; WriteReg_ID = 4;
        repeat (4) tick();
        checks++;
        if (MdBusy !== 1'b1 || obs === 72'd0) begin
            errors++; $display("FAIL reset_mid_pre busy=%b ex=%h want busy=1 ex!=0", MdBusy, obs);
        end
        reset_n = 0;
        #1;
        checks++;
        if (MdBusy !== 1'b0 || obs !== 72'd0) begin
            errors++; $display("FAIL reset_mid busy=%b ex=%h want busy=0 ex=0", MdBusy, obs);
        end
        #2 reset_n = 1;
        drive_md(MD_MFLO, 0, 0);
        exp_q.push_back({32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd2});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_lo got=%h want=%h", obs, e); end
        drive_md(MD_MFHI, 0, 0);
        exp_q.push_back({32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd2});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_hi got=%h want=%h", obs, e); end
        drive_nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu_fwd();
        test_stall_flush();
        test_div_signed();
        test_md_case("divu_by0", MD_DIVU, 32'd9, 32'd0, 33, 32'd9, 32'hFFFFFFFF);
        test_md_case("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000);
        test_md_case("div_negb", MD_DIV, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD);
        test_md_case("divu", MD_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        test_md_case("multu", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MULT_BUSY, 32'hFFFFFFFE, 32'd1);
        test_md_case("mult", MD_MULT, 32'hFFFFFFFD, 32'd5, MULT_BUSY, 32'hFFFFFFFF, 32'hFFFFFFF1);
        test_flush_no_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
